// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between the MEM stage and a single-port data memory.
// One access in flight: alignment check, strobed word request, grant/rdata wait, extended response.
module lsu_mem_ctrl #(
  parameter int TIMEOUT = 64,
  parameter int CNT_W   = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_func3,
  input  logic [4:0]  req_rd,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [4:0]  resp_rd,
  output logic        resp_err,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RD, RESP} state_t;

  state_t            state, state_nxt;
  logic              we_q;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic [2:0]        func3_q;
  logic [4:0]        rd_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              req_bad;
  logic              timeout_hit;

  // Illegal encodings, unsigned stores, and accesses crossing their natural alignment.
  function automatic logic access_bad(input logic we, input logic [2:0] f3, input logic [1:0] o);
    logic bad;
    case (f3)
      3'b000:  bad = 1'b0;
      3'b001:  bad = o[0];
      3'b010:  bad = |o;
      3'b100:  bad = we;
      3'b101:  bad = we | o[0];
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [31:0] load_ext(input logic [2:0] f3, input logic [1:0] o,
                                           input logic [31:0] rdata);
    logic [31:0] b;
    logic [31:0] h;
    logic [31:0] r;
    b = rdata >> {o, 3'b000};
    h = rdata >> {o[1], 4'b0000};
    case (f3)
      3'b000:  r = {{24{b[7]}}, b[7:0]};
      3'b001:  r = {{16{h[15]}}, h[15:0]};
      3'b100:  r = {24'b0, b[7:0]};
      3'b101:  r = {16'b0, h[15:0]};
      default: r = rdata;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_strb(input logic [2:0] f3, input logic [1:0] o);
    logic [3:0] s;
    case (f3)
      3'b000:  s = 4'b0001 << o;
      3'b001:  s = 4'b0011 << o;
      default: s = 4'b1111;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] d;
    case (f3)
      3'b000:  d = {4{wd[7:0]}};
      3'b001:  d = {2{wd[15:0]}};
      default: d = wd;
    endcase
    return d;
  endfunction

  assign req_bad     = access_bad(req_we, req_func3, req_addr[1:0]);
  assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt  = state;
    req_ready  = (state == IDLE);
    busy       = (state != IDLE);
    resp_valid = (state == RESP);
    mem_req    = (state == REQ);
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wstrb  = '0;
    mem_wdata  = '0;
    // Memory side is only driven while the request is being presented.
    if (state == REQ) begin
      mem_we   = we_q;
      mem_addr = {addr_q[31:2], 2'b00};
      if (we_q) begin
        mem_wstrb = store_strb(func3_q, addr_q[1:0]);
        mem_wdata = store_data(func3_q, wdata_q);
      end
    end
    case (state)
      IDLE:    if (req_valid) state_nxt = req_bad ? RESP : REQ;
      REQ:     if (mem_gnt) state_nxt = we_q ? RESP : WAIT_RD;
      WAIT_RD: if (mem_rvalid || timeout_hit) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      func3_q   <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      resp_data <= '0;
      resp_rd   <= '0;
      resp_err  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            func3_q <= req_func3;
            rd_q    <= req_rd;
            if (req_bad) begin
              resp_data <= '0;
              resp_rd   <= req_rd;
              resp_err  <= 1'b1;
            end
          end
        end
        REQ: begin
          if (mem_gnt) begin
            cnt_q <= '0;
            if (we_q) begin
              resp_data <= '0;
              resp_rd   <= rd_q;
              resp_err  <= 1'b0;
            end
          end
        end
        WAIT_RD: begin
          cnt_q <= cnt_q + CNT_W'(1);
          // Data arriving on the last allowed cycle still beats the timeout.
          if (mem_rvalid) begin
            resp_data <= load_ext(func3_q, addr_q[1:0], mem_rdata);
            resp_rd   <= rd_q;
            resp_err  <= 1'b0;
          end else if (timeout_hit) begin
            resp_data <= '0;
            resp_rd   <= rd_q;
            resp_err  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: directed vector table, hand sequences for reset abort,
// and randomized accesses against a behavioural reference model.
module tb_lsu_mem_ctrl;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [2:0]  req_func3;
  logic [4:0]  req_rd;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        resp_valid, resp_err, busy;
  logic [31:0] resp_data;
  logic [4:0]  resp_rd;

  int total = 0;
  int bad   = 0;

  lsu_mem_ctrl #(.TIMEOUT(TO), .CNT_W(7)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_func3(req_func3), .req_rd(req_rd),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wstrb(mem_wstrb),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd), .resp_err(resp_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] rdata;
    int          gd;
    int          rvd;
    logic [31:0] e_data;
    logic        e_err;
    int          e_lat;
    logic [3:0]  e_strb;
    logic [31:0] e_wd;
  } vec_t;

  vec_t tbl[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: what a correct controller must return for one access.
  task automatic model(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [2:0] f3, input logic [31:0] rdata, input int gd, input int rvd,
                       output logic [31:0] e_data, output logic e_err, output int e_lat,
                       output logic [3:0] e_strb, output logic [31:0] e_wd);
    int unsigned o, b, h;
    bit legal;
    o = a % 4;
    case (f3)
      3'b000:  legal = 1;
      3'b001:  legal = (o % 2) == 0;
      3'b010:  legal = (o == 0);
      3'b100:  legal = !we;
      3'b101:  legal = !we && (o % 2) == 0;
      default: legal = 0;
    endcase
    b = (rdata >> (8 * o)) & 32'hFF;
    h = (rdata >> (16 * (o / 2))) & 32'hFFFF;
    e_data = 0; e_err = 0; e_strb = 0; e_wd = 0;
    if (!legal) begin
      e_err = 1; e_lat = 1;
    end else if (we) begin
      e_lat = 2 + gd;
      case (f3)
        3'b000:  begin e_strb = 4'(1 << o); e_wd = 32'h01010101 * (wd & 32'hFF); end
        3'b001:  begin e_strb = 4'(3 << o); e_wd = 32'h00010001 * (wd & 32'hFFFF); end
        default: begin e_strb = 4'hF;       e_wd = wd; end
      endcase
    end else if (rvd >= TO) begin
      e_err = 1; e_lat = 2 + TO;
    end else begin
      e_lat = 3 + gd + rvd;
      case (f3)
        3'b000:  e_data = (b >= 128) ? b - 256 : b;
        3'b001:  e_data = (h >= 32768) ? h - 65536 : h;
        3'b100:  e_data = b;
        3'b101:  e_data = h;
        default: e_data = rdata;
      endcase
    end
  endtask

  // Issues one access, plays the memory with the given grant/rvalid delays, checks everything.
  task automatic run_access(input string nm, input vec_t v, input bit noise);
    int lat, nreq, wcyc, e_nreq;
    bit granted, done, unstable;
    logic [31:0] a0, w0, got_data;
    logic [3:0]  s0;
    logic        we0;
    lat = 0; nreq = 0; wcyc = 0; granted = 0; done = 0; unstable = 0;
    a0 = 0; w0 = 0; s0 = 0; we0 = 0;
    chk({nm, ".ready"}, {31'b0, req_ready}, 32'd1);
    req_valid = 1; req_we = v.we; req_addr = v.addr; req_wdata = v.wd;
    req_func3 = v.f3; req_rd = v.rd;
    tick();
    req_valid = 0;
    if (noise) begin req_addr = $urandom; req_wdata = $urandom; req_func3 = 3'($urandom); end
    lat = 1;
    while (!done && lat < 200) begin
      mem_gnt = 0; mem_rvalid = 0; mem_rdata = noise ? $urandom : 32'h0;
      if (resp_valid) done = 1;
      else if (mem_req) begin
        if (nreq == 0) begin a0 = mem_addr; w0 = mem_wdata; s0 = mem_wstrb; we0 = mem_we; end
        else if (a0 !== mem_addr || w0 !== mem_wdata || s0 !== mem_wstrb || we0 !== mem_we)
          unstable = 1;
        if (nreq == v.gd) begin mem_gnt = 1; granted = 1; end
        else if (noise) mem_rvalid = 1'($urandom);
        nreq++;
      end else if (granted) begin
        if (wcyc == v.rvd) begin mem_rvalid = 1; mem_rdata = v.rdata; end
        else if (noise) mem_gnt = 1'($urandom);
        wcyc++;
      end
      if (!done) begin tick(); lat++; end
    end
    mem_gnt = 0; mem_rvalid = 0;
    e_nreq = (v.e_lat == 1) ? 0 : v.gd + 1;
    chk({nm, ".latency"}, 32'(lat), 32'(v.e_lat));
    chk({nm, ".data"}, resp_data, v.e_data);
    chk({nm, ".err"}, {31'b0, resp_err}, {31'b0, v.e_err});
    chk({nm, ".rd"}, {27'b0, resp_rd}, {27'b0, v.rd});
    chk({nm, ".nreq"}, 32'(nreq), 32'(e_nreq));
    if (e_nreq > 0) begin
      chk({nm, ".stable"}, {31'b0, unstable}, 32'd0);
      chk({nm, ".addr"}, a0, v.addr & 32'hFFFF_FFFC);
      chk({nm, ".we"}, {31'b0, we0}, {31'b0, v.we});
      chk({nm, ".wstrb"}, {28'b0, s0}, {28'b0, v.e_strb});
      chk({nm, ".wdata"}, w0, v.e_wd);
    end
    got_data = resp_data;
    tick();
    chk({nm, ".pulse"}, {31'b0, resp_valid}, 32'd0);
    chk({nm, ".hold"}, resp_data, got_data);
  endtask

  initial begin
    vec_t v;
    rst = 1; req_valid = 0; req_we = 0; req_addr = 0; req_wdata = 0; req_func3 = 0; req_rd = 0;
    mem_gnt = 0; mem_rvalid = 0; mem_rdata = 0;

    tbl[0]  = '{0, 32'h1003, 0, 3'b000, 5'd1, 32'h80FF1234, 0, 0, 32'hFFFFFF80, 0, 3, 0, 0};
    tbl[1]  = '{0, 32'h2002, 0, 3'b101, 5'd2, 32'h80017FFF, 0, 0, 32'h00008001, 0, 3, 0, 0};
    tbl[2]  = '{0, 32'h2002, 0, 3'b001, 5'd3, 32'h80017FFF, 0, 0, 32'hFFFF8001, 0, 3, 0, 0};
    tbl[3]  = '{1, 32'h3001, 32'hA5, 3'b000, 5'd4, 0, 4, 0, 0, 0, 6, 4'b0010, 32'hA5A5A5A5};
    tbl[4]  = '{0, 32'h4002, 0, 3'b010, 5'd5, 32'hFFFFFFFF, 0, 0, 0, 1, 1, 0, 0};
    tbl[5]  = '{1, 32'h3000, 32'h11, 3'b100, 5'd6, 0, 0, 0, 0, 1, 1, 0, 0};
    tbl[6]  = '{1, 32'h5000, 32'h12345678, 3'b010, 5'd7, 0, 0, 0, 0, 0, 2, 4'hF, 32'h12345678};
    tbl[7]  = '{1, 32'h6002, 32'h1234BEEF, 3'b001, 5'd8, 0, 1, 0, 0, 0, 3, 4'b1100, 32'hBEEFBEEF};
    tbl[8]  = '{0, 32'h7001, 0, 3'b100, 5'd9, 32'h00008000, 0, 0, 32'h00000080, 0, 3, 0, 0};
    tbl[9]  = '{0, 32'h8004, 0, 3'b010, 5'd10, 32'hDEADBEEF, 2, 1, 32'hDEADBEEF, 0, 6, 0, 0};
    tbl[10] = '{0, 32'h0010, 0, 3'b011, 5'd11, 0, 0, 0, 0, 1, 1, 0, 0};
    tbl[11] = '{0, 32'h9001, 0, 3'b001, 5'd12, 0, 0, 0, 0, 1, 1, 0, 0};
    tbl[12] = '{0, 32'hA000, 0, 3'b010, 5'd13, 32'h5555AAAA, 0, 1000, 0, 1, TO + 2, 0, 0};
    tbl[13] = '{0, 32'hA000, 0, 3'b010, 5'd14, 32'h5555AAAA, 0, TO - 1, 32'h5555AAAA, 0, TO + 2, 0, 0};

    tick(); tick();
    rst = 0;
    chk("reset.ready", {31'b0, req_ready}, 32'd1);
    chk("reset.busy", {31'b0, busy}, 32'd0);
    chk("reset.mem_req", {31'b0, mem_req}, 32'd0);
    chk("reset.resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("reset.resp", {resp_data[26:0], resp_rd}, 32'd0);
    chk("reset.err", {31'b0, resp_err}, 32'd0);

    for (int i = 0; i < 14; i++) run_access($sformatf("vec%0d", i), tbl[i], 1'b0);

    // Reset while waiting for read data: aborted silently, late rvalid ignored.
    req_valid = 1; req_we = 0; req_addr = 32'h40; req_func3 = 3'b010; req_rd = 5'd20;
    tick();
    req_valid = 0; mem_gnt = 1;
    tick();
    mem_gnt = 0;
    chk("abort.busy_wait", {31'b0, busy}, 32'd1);
    chk("abort.no_req_wait", {31'b0, mem_req}, 32'd0);
    tick(); tick();
    rst = 1;
    tick();
    rst = 0;
    chk("abort.ready", {31'b0, req_ready}, 32'd1);
    chk("abort.busy", {31'b0, busy}, 32'd0);
    chk("abort.resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("abort.resp_data", resp_data, 32'd0);
    mem_rvalid = 1; mem_rdata = 32'hCAFEF00D;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort.late_rvalid", {30'b0, resp_valid, busy}, 32'd0);
    end
    mem_rvalid = 0;

    for (int i = 0; i < 150; i++) begin
      logic [2:0] f3s[7];
      f3s = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b111};
      v.we = 1'($urandom); v.addr = $urandom; v.wd = $urandom;
      v.f3 = f3s[$urandom_range(0, 6)]; v.rd = 5'($urandom); v.rdata = $urandom;
      v.gd = $urandom_range(0, 3); v.rvd = $urandom_range(0, 4);
      model(v.we, v.addr, v.wd, v.f3, v.rdata, v.gd, v.rvd,
            v.e_data, v.e_err, v.e_lat, v.e_strb, v.e_wd);
      run_access($sformatf("rnd%0d", i), v, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
